// File: rtl/router_pkg.sv
// Shared types and constants for the router control slice.
// The optional WAIT_TILL_EMPTY timeout is enabled by ROUTER_FSM_WAIT_TIMEOUT_EN.
package router_pkg;

  localparam int ADDR_W       = 2;
  localparam int NUM_PORTS    = 3;
  localparam int WAIT_TIMEOUT = 30;
  localparam int TMR_W        = 5;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for WAIT_TILL_EMPTY; expires on the last permitted wait cycle.
// Only instantiated when ROUTER_FSM_WAIT_TIMEOUT_EN is defined.
module router_wait_timer
  import router_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic i_en,
  output logic o_expired
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn)   r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
    else           r_cnt <= '0;
  end

  // Count equals cycles already spent waiting, so WAIT_TIMEOUT-1 is the final one.
  assign o_expired = i_en && (r_cnt == TMR_W'(WAIT_TIMEOUT - 1));

endmodule

// File: rtl/router_fsm_ctrl.sv
// Router input controller: Moore FSM steering header/payload/parity loading.
// Define ROUTER_FSM_WAIT_TIMEOUT_EN to bound WAIT_TILL_EMPTY and expose wait_timeout.
module router_fsm_ctrl
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  ,
  output logic                 wait_timeout
`endif
);

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr_q;
  logic                w_hdr_ok;
  logic                w_port_rst;
  logic                w_tmo;

  assign w_hdr_ok   = pkt_valid && (data_in != 2'd3);
  assign w_port_rst = soft_reset[r_addr_q];

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  logic w_expired;

  router_wait_timer u_wait_timer (
    .clk       (clk),
    .resetn    (resetn),
    .i_en      (r_state == WAIT_TILL_EMPTY),
    .o_expired (w_expired)
  );

  assign w_tmo        = w_expired && !fifo_empty[r_addr_q];
  assign wait_timeout = w_tmo;
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= DECODE_ADDRESS;
      r_addr_q <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE_ADDRESS && w_hdr_ok)
        r_addr_q <= data_in;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      DECODE_ADDRESS: begin
        if (w_hdr_ok)
          w_next = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: w_next = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       w_next = FIFO_FULL_STATE;
        else if (!pkt_valid) w_next = LOAD_PARITY;
      end
      LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      FIFO_FULL_STATE:    if (!fifo_full) w_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        w_next = DECODE_ADDRESS;
        else if (low_pkt_valid) w_next = LOAD_PARITY;
        else                    w_next = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        if (fifo_empty[r_addr_q]) w_next = LOAD_FIRST_DATA;
        else if (w_tmo)           w_next = DECODE_ADDRESS;
      end
      default: w_next = DECODE_ADDRESS;
    endcase
    // A soft reset on the active port aborts the packet from any busy state.
    if (r_state != DECODE_ADDRESS && w_port_rst)
      w_next = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (r_state == DECODE_ADDRESS);
    lfd_state     = (r_state == LOAD_FIRST_DATA);
    ld_state      = (r_state == LOAD_DATA);
    laf_state     = (r_state == LOAD_AFTER_FULL);
    full_state    = (r_state == FIFO_FULL_STATE);
    rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                    (r_state == LOAD_AFTER_FULL);
    busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);
  end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed bench for router_fsm_ctrl; outputs checked as one packed vector per state.
// Covers the ROUTER_FSM_WAIT_TIMEOUT_EN build when that macro is defined.
module tb_router_fsm_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic write_enb_reg, busy;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  logic wait_timeout;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  localparam logic [7:0] S_DA  = 8'b1000_0000;
  localparam logic [7:0] S_LFD = 8'b0100_0001;
  localparam logic [7:0] S_LD  = 8'b0010_0010;
  localparam logic [7:0] S_LAF = 8'b0001_0011;
  localparam logic [7:0] S_FUL = 8'b0000_1001;
  localparam logic [7:0] S_CPE = 8'b0000_0101;
  localparam logic [7:0] S_LP  = 8'b0000_0011;
  localparam logic [7:0] S_WTE = 8'b0000_0001;

  logic [7:0] w_out;
  assign w_out = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  rst_int_reg, write_enb_reg, busy};

  router_fsm_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .soft_reset    (soft_reset),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy)
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    ,
    .wait_timeout  (wait_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    n_assert++;
    assert (w_out === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, w_out, exp);
    end
  endtask

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  task automatic chk_to(input string tag, input logic exp);
    n_assert++;
    assert (wait_timeout === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed wait_timeout=%b expected %b", tag, wait_timeout, exp);
    end
  endtask
`endif

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;

    // Reset, with a valid header presented to show reset dominates
    tick();
    pkt_valid = 1'b1; data_in = 2'b01;
    tick();
    chk("reset", S_DA);
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    chk_to("reset_to", 1'b0);
`endif
    resetn = 1'b1;

    // Header 0x49 -> addr 1, 17 payload cycles then parity
    tick(); chk("p1_lfd", S_LFD);
    for (int i = 0; i < 17; i++) begin
      tick(); chk("p1_ld", S_LD);
      if (i == 16) pkt_valid = 1'b0;
    end
    tick(); chk("p1_lp", S_LP);
    tick(); chk("p1_cpe", S_CPE);
    tick(); chk("p1_da", S_DA);
    tick(); chk("idle_da", S_DA);

    // Addr 2 with port 2 not empty -> wait, then release
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    tick(); chk("wte", S_WTE);
    tick(); chk("wte_hold", S_WTE);
    fifo_empty = 3'b111;
    tick(); chk("wte_lfd", S_LFD);
    tick(); chk("p2_ld", S_LD);

    // Full for 4 cycles; fifo_full beats pkt_valid=0
    fifo_full = 1'b1; pkt_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("full", S_FUL);
      if (i == 3) fifo_full = 1'b0;
      tick();
    end
    chk("laf", S_LAF);
    low_pkt_valid = 1'b1;
    tick(); chk("laf_lp", S_LP);
    low_pkt_valid = 1'b0; fifo_full = 1'b1;
    tick(); chk("cpe_full", S_CPE);
    tick(); chk("cpe_to_full", S_FUL);
    fifo_full = 1'b0; parity_done = 1'b1; low_pkt_valid = 1'b1;
    tick(); chk("laf2", S_LAF);
    tick(); chk("laf_pdone_da", S_DA);
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    // LAF with neither status -> back to LOAD_DATA
    pkt_valid = 1'b1; data_in = 2'd0;
    tick(); chk("p3_lfd", S_LFD);
    tick(); chk("p3_ld", S_LD);
    fifo_full = 1'b1;
    tick(); chk("p3_full", S_FUL);
    fifo_full = 1'b0;
    tick(); chk("p3_laf", S_LAF);
    tick(); chk("p3_laf_ld", S_LD);
    pkt_valid = 1'b0;
    tick(); chk("p3_lp", S_LP);
    tick(); chk("p3_cpe", S_CPE);
    tick(); chk("p3_da", S_DA);

    // Invalid address 3 is dropped
    pkt_valid = 1'b1; data_in = 2'd3;
    tick(); chk("addr3_a", S_DA);
    tick(); chk("addr3_b", S_DA);

    // Soft reset on the active port aborts; on another port does nothing
    data_in = 2'd1;
    tick(); chk("sr_lfd", S_LFD);
    tick(); chk("sr_ld", S_LD);
    soft_reset = 3'b010;
    tick(); chk("sr_abort_ld", S_DA);
    tick(); chk("sr_ignored_da", S_LFD);
    tick(); chk("sr_abort_lfd", S_DA);
    soft_reset = 3'b000;
    tick(); chk("sr2_lfd", S_LFD);
    tick(); chk("sr2_ld", S_LD);
    soft_reset = 3'b001;
    tick(); chk("sr_other_port", S_LD);
    soft_reset = 3'b000; pkt_valid = 1'b0;
    tick(); chk("sr2_lp", S_LP);
    tick(); chk("sr2_cpe", S_CPE);
    tick(); chk("sr2_da", S_DA);

    // Soft reset while waiting
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
    tick(); chk("sr_wte", S_WTE);
    pkt_valid = 1'b0; soft_reset = 3'b010;
    tick(); chk("sr_abort_wte", S_DA);
    soft_reset = 3'b000; fifo_empty = 3'b111;

    // Hard reset mid-packet
    pkt_valid = 1'b1; data_in = 2'd0;
    tick(); chk("hr_lfd", S_LFD);
    tick(); chk("hr_ld", S_LD);
    resetn = 1'b0;
    tick(); chk("hr_da", S_DA);
    resetn = 1'b1;

    // Long wait on port 0
    fifo_empty = 3'b110;
    tick(); chk("tmo_wte", S_WTE);
    pkt_valid = 1'b0;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    for (int i = 0; i < 30; i++) begin
      chk("tmo_wait", S_WTE);
      chk_to("tmo_pulse", (i == 29));
      tick();
    end
    chk("tmo_da", S_DA);
    chk_to("tmo_after", 1'b0);
`else
    for (int i = 0; i < 40; i++) begin
      tick(); chk("wait_forever", S_WTE);
    end
    fifo_empty = 3'b111;
    tick(); chk("wait_rel_lfd", S_LFD);
    tick(); chk("wait_rel_ld", S_LD);
    tick(); chk("wait_rel_lp", S_LP);
    tick(); chk("wait_rel_cpe", S_CPE);
    tick(); chk("wait_rel_da", S_DA);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fsm_ctrl.md
ROUTER_FSM_CTRL -- requirements
Module: router_fsm_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have port: resetn  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have port: pkt_valid  input  1  source asserts while header/payload bytes are presented; deasserts on the parity byte.
REQ-004 SHALL have port: data_in  input  2  header bits [1:0] (destination address) from the input byte.
REQ-005 SHALL have port: fifo_full  input  1  selected output FIFO full.
REQ-006 SHALL have port: fifo_empty  input  3  per-port output FIFO empty, bit n = port n.
REQ-007 SHALL have port: soft_reset  input  3  per-port soft reset from the synchronizer.
REQ-008 SHALL have ports: parity_done, low_pkt_valid  input  1 each  status from router_reg.
REQ-009 SHALL have ports: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  output  1 each  state strobes to router_reg.
REQ-010 SHALL have ports: write_enb_reg  output  1  FIFO write enable request; busy  output  1  back-pressure to source.

Function
REQ-011 SHALL implement the Moore FSM states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
REQ-012 SHALL latch data_in into addr_q in DECODE_ADDRESS when pkt_valid=1 and data_in!=3.
REQ-013 DECODE_ADDRESS: pkt_valid=1, data_in<3, fifo_empty[data_in]=1 -> LOAD_FIRST_DATA; pkt_valid=1, data_in<3, fifo_empty[data_in]=0 -> WAIT_TILL_EMPTY; data_in=3 or pkt_valid=0 -> stay (packet dropped).
REQ-014 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-015 LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay; fifo_full takes priority.
REQ-016 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-017 CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-018 FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-019 LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else -> LOAD_DATA; parity_done has priority.
REQ-020 WAIT_TILL_EMPTY: fifo_empty[addr_q]=1 -> LOAD_FIRST_DATA; else stay.
REQ-021 soft_reset[addr_q]=1 in any state other than DECODE_ADDRESS SHALL force DECODE_ADDRESS next cycle, overriding all other transitions.
REQ-022 Outputs SHALL decode current state only: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR.
REQ-023 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; busy SHALL be 1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-024 Output latency SHALL be zero cycles from state register (no registered outputs).

Reset
REQ-025 resetn=0 at a rising edge SHALL set state=DECODE_ADDRESS, addr_q=0, timeout counter=0, regardless of current state or inputs.
REQ-026 During and after reset: detect_add=1, all other outputs 0.

Configuration
REQ-027 Macro ROUTER_FSM_WAIT_TIMEOUT_EN defined: 5-bit counter increments each cycle in WAIT_TILL_EMPTY, clears elsewhere; at count 29 with fifo_empty[addr_q]=0 -> DECODE_ADDRESS and output wait_timeout (1-bit) pulses 1 cycle.
REQ-028 Macro undefined: no counter, no wait_timeout port, WAIT_TILL_EMPTY waits indefinitely.

Structure
REQ-029 State enum (3-bit binary), ADDR_W=2, NUM_PORTS=3, WAIT_TIMEOUT=30 SHALL live in shared package router_pkg.
REQ-030 Timeout counter SHALL be sub-module router_wait_timer, instantiated only under ROUTER_FSM_WAIT_TIMEOUT_EN; no other sub-modules.

Verification
REQ-031 Reset, then header 0x49 (addr 1), fifo_empty=3'b111, pkt_valid held 18 cycles -> detect_add, lfd_state, then ld_state 17 cycles, LOAD_PARITY, rst_int_reg 1 cycle, back to detect_add.
REQ-032 Header addr 2 with fifo_empty=3'b011 -> WAIT_TILL_EMPTY, busy=1; set fifo_empty[2]=1 -> lfd_state next cycle.
REQ-033 fifo_full=1 in LOAD_DATA for 4 cycles -> full_state 4 cycles, write_enb_reg=0, then laf_state; low_pkt_valid=1 -> LOAD_PARITY.
REQ-034 Header data_in=3, pkt_valid=1 -> remains DECODE_ADDRESS, busy=0, write_enb_reg=0.
REQ-035 soft_reset[1]=1 mid-packet to addr 1 -> DECODE_ADDRESS next cycle; soft_reset[0]=1 same scenario -> no effect.
REQ-036 With ROUTER_FSM_WAIT_TIMEOUT_EN, fifo_empty[0]=0 held 40 cycles after addr-0 header -> wait_timeout pulse 30 cycles after entry, then detect_add=1.
